// File: rtl/fmdll_pkg.sv
// Shared encodings and defaults for the FMDLL edge-select sequencer.
package fmdll_pkg;

    localparam logic [1:0] SEL_REF  = 2'b00;
    localparam logic [1:0] SEL_LOOP = 2'b10;
    localparam logic [1:0] SEL_LAST = 2'b01;

    localparam int unsigned NW_DEF    = 4;
    localparam int unsigned MW_DEF    = 2;
    localparam int unsigned N_DEF_VAL = 4;
    localparam int unsigned M_DEF_VAL = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fmdll_nm_counter.sv
// Nested N/M wrap counters; exposes next values so Sel can be registered in step with them.
module fmdll_nm_counter
    import fmdll_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk_out,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic          inc,
    input  logic [NW-1:0] n_act,
    input  logic [MW-1:0] m_act,
    output logic [NW-1:0] n_cnt,
    output logic [MW-1:0] m_cnt,
    output logic [NW-1:0] n_nxt,
    output logic [MW-1:0] m_nxt,
    output logic          div_n,
    output logic          div_m
);

    logic [NW-1:0] n_cnt_q, n_cnt_d;
    logic [MW-1:0] m_cnt_q, m_cnt_d;

    assign div_n = (n_cnt_q == n_act);
    assign div_m = div_n && (m_cnt_q == m_act);

    always_comb begin
        n_cnt_d = n_cnt_q;
        m_cnt_d = m_cnt_q;
        if (clr) begin
            n_cnt_d = '0;
            m_cnt_d = '0;
        end else if (ld) begin
            n_cnt_d = NW'(1);
            m_cnt_d = MW'(1);
        end else if (inc) begin
            if (div_n) begin
                n_cnt_d = NW'(1);
                m_cnt_d = (m_cnt_q == m_act) ? MW'(1) : m_cnt_q + MW'(1);
            end else begin
                n_cnt_d = n_cnt_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt_q <= '0;
            m_cnt_q <= '0;
        end else begin
            n_cnt_q <= n_cnt_d;
            m_cnt_q <= m_cnt_d;
        end
    end

    assign n_cnt = n_cnt_q;
    assign m_cnt = m_cnt_q;
    assign n_nxt = n_cnt_d;
    assign m_nxt = m_cnt_d;

endmodule

// File: rtl/fmdll_nm_sequencer.sv
// FMDLL edge-select sequencer: start/stop FSM, frame-aligned config shadow and Sel register.
//   state | meaning
//   IDLE  | counters 0, Sel=10; pending config applied here
//   ARM   | one cycle; applies pending, loads counters to (1,1)
//   RUN   | counting; en low moves to STOP
//   STOP  | counting until the frame ends (then IDLE) or en returns (RUN)
module fmdll_nm_sequencer
    import fmdll_pkg::*;
#(
    parameter int NW    = NW_DEF,
    parameter int MW    = MW_DEF,
    parameter int N_DEF = N_DEF_VAL,
    parameter int M_DEF = M_DEF_VAL
) (
    input  logic          clk_out,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_load,
    input  logic [NW-1:0] cfg_N,
    input  logic [MW-1:0] cfg_M,
    output logic          cfg_ack,
    output logic          cfg_err,
    output logic [NW-1:0] N_counter,
    output logic [MW-1:0] M_counter,
    output logic          DIV_N,
    output logic          DIV_M,
    output logic          frame_start,
    output logic [1:0]    Sel,
    output logic          busy
);

    seq_state_e    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [NW-1:0] n_act_q, n_act_d, pend_n_q, pend_n_d;
    logic [MW-1:0] m_act_q, m_act_d, pend_m_q, pend_m_d;
    logic          pend_vld_q, pend_vld_d;
    logic          cfg_ack_q, cfg_ack_d, cfg_err_q, cfg_err_d;

    logic          cnt_clr, cnt_ld, cnt_inc;
    logic [NW-1:0] n_cnt, n_nxt;
    logic [MW-1:0] m_cnt, m_nxt;
    logic          div_n, div_m;
    logic          cfg_legal, apply;

    fmdll_nm_counter #(.NW(NW), .MW(MW)) u_cnt (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .ld      (cnt_ld),
        .inc     (cnt_inc),
        .n_act   (n_act_q),
        .m_act   (m_act_q),
        .n_cnt   (n_cnt),
        .m_cnt   (m_cnt),
        .n_nxt   (n_nxt),
        .m_nxt   (m_nxt),
        .div_n   (div_n),
        .div_m   (div_m)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_ld  = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (en) state_d = ARM;
            end
            ARM: begin
                cnt_ld  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_inc = 1'b1;
                if (!en) state_d = STOP;
            end
            STOP: begin
                if (en) begin
                    cnt_inc = 1'b1;
                    state_d = RUN;
                end else if (div_m) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sel follows the counter values it will sit beside next cycle
        sel_d = sel_q;
        if (state_d == IDLE) begin
            sel_d = SEL_LOOP;
        end else if (cnt_ld || cnt_inc) begin
            if (m_nxt == MW'(1))                              sel_d = SEL_REF;
            else if (n_nxt == n_act_q && m_nxt != m_act_q)    sel_d = SEL_LOOP;
            else if (n_nxt == n_act_q)                        sel_d = SEL_LAST;
        end

        // N/M only change where no frame is in flight
        cfg_legal = (cfg_N != '0) && (cfg_M != '0);
        apply     = pend_vld_q && ((state_q == IDLE) || (state_q == ARM) || div_m);

        n_act_d    = apply ? pend_n_q : n_act_q;
        m_act_d    = apply ? pend_m_q : m_act_q;
        pend_n_d   = pend_n_q;
        pend_m_d   = pend_m_q;
        pend_vld_d = pend_vld_q && !apply;
        if (cfg_load && cfg_legal) begin
            pend_n_d   = cfg_N;
            pend_m_d   = cfg_M;
            pend_vld_d = 1'b1;
        end
        cfg_ack_d = apply;
        cfg_err_d = cfg_load && !cfg_legal;
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= SEL_LOOP;
            n_act_q    <= NW'(N_DEF);
            m_act_q    <= MW'(M_DEF);
            pend_n_q   <= '0;
            pend_m_q   <= '0;
            pend_vld_q <= 1'b0;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            n_act_q    <= n_act_d;
            m_act_q    <= m_act_d;
            pend_n_q   <= pend_n_d;
            pend_m_q   <= pend_m_d;
            pend_vld_q <= pend_vld_d;
            cfg_ack_q  <= cfg_ack_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign N_counter   = n_cnt;
    assign M_counter   = m_cnt;
    assign DIV_N       = div_n;
    assign DIV_M       = div_m;
    assign frame_start = (n_cnt == NW'(1)) && (m_cnt == MW'(1));
    assign Sel         = sel_q;
    assign busy        = (state_q != IDLE);
    assign cfg_ack     = cfg_ack_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_fmdll_nm_sequencer.sv
// Table-driven bench for fmdll_nm_sequencer: each row drives one cycle and queues the outputs expected after it.
module tb_fmdll_nm_sequencer;

    logic       clk_out = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cfg_load;
    logic [3:0] cfg_N;
    logic [1:0] cfg_M;
    logic       cfg_ack, cfg_err, DIV_N, DIV_M, frame_start, busy;
    logic [3:0] N_counter;
    logic [1:0] M_counter;
    logic [1:0] Sel;

    int errors = 0;
    int checks = 0;

    // exp layout: {busy, N, M, Sel, DIV_N, DIV_M, frame_start, cfg_ack, cfg_err}
    typedef struct {
        logic        en;
        logic        ld;
        logic [3:0]  cn;
        logic [1:0]  cm;
        logic [13:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [13:0] exp_q[$];

    fmdll_nm_sequencer dut (
        .clk_out     (clk_out),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_N       (cfg_N),
        .cfg_M       (cfg_M),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err),
        .N_counter   (N_counter),
        .M_counter   (M_counter),
        .DIV_N       (DIV_N),
        .DIV_M       (DIV_M),
        .frame_start (frame_start),
        .Sel         (Sel),
        .busy        (busy)
    );

    always #5 clk_out = ~clk_out;

    function automatic vec_t v(input logic en_i, input logic ld_i, input int cn_i, input int cm_i,
                               input logic b, input int n, input int m, input int s,
                               input logic dn, input logic dm, input logic fs,
                               input logic ack, input logic err);
        vec_t r;
        r.en  = en_i;
        r.ld  = ld_i;
        r.cn  = 4'(cn_i);
        r.cm  = 2'(cm_i);
        r.exp = {b, 4'(n), 2'(m), 2'(s), dn, dm, fs, ack, err};
        return r;
    endfunction

    function automatic vec_t run(input logic en_i, input int n, input int m, input int s,
                                 input logic dn, input logic dm, input logic fs);
        return v(en_i, 1'b0, 0, 0, 1'b1, n, m, s, dn, dm, fs, 1'b0, 1'b0);
    endfunction

    function automatic vec_t idle(input logic en_i, input logic ack);
        return v(en_i, 1'b0, 0, 0, 1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0, ack, 1'b0);
    endfunction

    function automatic vec_t arm();
        return v(1'b1, 1'b0, 0, 0, 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check_pop(input string name);
        logic [13:0] e, g;
        checks++;
        g = {busy, N_counter, M_counter, Sel, DIV_N, DIV_M, frame_start, cfg_ack, cfg_err};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued, got %b", name, g);
            return;
        end
        e = exp_q.pop_front();
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got b/N/M/Sel/dn/dm/fs/ack/err=%b expected %b", name, g, e);
        end
    endtask

    task automatic step(input vec_t r, input string name);
        @(negedge clk_out);
        en       = r.en;
        cfg_load = r.ld;
        cfg_N    = r.cn;
        cfg_M    = r.cm;
        exp_q.push_back(r.exp);
        @(posedge clk_out);
        #1;
        check_pop(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // defaults N=4, M=2
        tbl.push_back(idle(1'b0, 1'b0));
        tbl.push_back(arm());
        tbl.push_back(run(1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(run(1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 4, 1, 0, 1, 0, 0));
        tbl.push_back(run(1, 1, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 2, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 4, 2, 1, 1, 1, 0));
        tbl.push_back(run(1, 1, 1, 0, 0, 0, 1));
        // load 3,3 mid-frame: takes effect only after the frame wraps
        tbl.push_back(v(1, 1, 3, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 4, 1, 0, 1, 0, 0));
        tbl.push_back(run(1, 1, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 2, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 4, 2, 1, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(run(1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 1, 0, 1, 0, 0));
        tbl.push_back(run(1, 1, 2, 0, 0, 0, 0));
        tbl.push_back(run(1, 2, 2, 0, 0, 0, 0));
        // load 2,1 while at (2,2) of the 3x3 frame
        tbl.push_back(v(1, 1, 2, 1, 1, 3, 2, 2, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 1, 3, 2, 0, 0, 0));
        tbl.push_back(run(1, 2, 3, 2, 0, 0, 0));
        tbl.push_back(run(1, 3, 3, 1, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(run(1, 2, 1, 0, 1, 1, 0));
        // illegal N=0
        tbl.push_back(v(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(run(1, 2, 1, 0, 1, 1, 0));
        tbl.push_back(run(1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(run(1, 2, 1, 0, 1, 1, 0));
        // back to 3,3
        tbl.push_back(v(1, 1, 3, 3, 1, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(run(1, 2, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(run(1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(run(1, 3, 1, 0, 1, 0, 0));
        tbl.push_back(run(1, 1, 2, 0, 0, 0, 0));
        // en drops at (1,2): frame finishes, then idle
        tbl.push_back(run(0, 2, 2, 0, 0, 0, 0));
        tbl.push_back(run(0, 3, 2, 2, 1, 0, 0));
        tbl.push_back(run(0, 1, 3, 2, 0, 0, 0));
        tbl.push_back(run(0, 2, 3, 2, 0, 0, 0));
        tbl.push_back(run(0, 3, 3, 1, 1, 1, 0));
        tbl.push_back(idle(1'b0, 1'b0));
        // load 1,3 in IDLE: applied the following cycle
        tbl.push_back(v(0, 1, 1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1'b0, 1'b1));
        tbl.push_back(arm());
        tbl.push_back(run(1, 1, 1, 0, 1, 0, 1));
        tbl.push_back(run(1, 1, 2, 2, 1, 0, 0));
        tbl.push_back(run(1, 1, 3, 1, 1, 1, 0));
        tbl.push_back(run(1, 1, 1, 0, 1, 0, 1));
        // en dips and returns before DIV_M, then dips exactly at DIV_M
        tbl.push_back(run(0, 1, 2, 2, 1, 0, 0));
        tbl.push_back(run(1, 1, 3, 1, 1, 1, 0));
        tbl.push_back(run(0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(run(1, 1, 2, 2, 1, 0, 0));
        tbl.push_back(run(1, 1, 3, 1, 1, 1, 0));

        rst_n = 1'b0; en = 1'b1; cfg_load = 1'b0; cfg_N = '0; cfg_M = '0;
        #12;
        exp_q.push_back(idle(1'b0, 1'b0).exp);
        check_pop("reset_state");
        @(negedge clk_out);
        en    = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

        // pending 5,3 queued mid-frame, then reset between edges must drop it
        step(v(1, 1, 5, 3, 1, 1, 1, 0, 1, 0, 1, 0, 0), "load_before_reset");
        @(negedge clk_out);
        #2;
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0;
        #1;
        exp_q.push_back(idle(1'b0, 1'b0).exp);
        check_pop("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_out);
            #1;
            exp_q.push_back(idle(1'b0, 1'b0).exp);
            check_pop($sformatf("reset_hold%0d", i));
        end
        @(negedge clk_out);
        rst_n = 1'b1;
        step(idle(1'b0, 1'b0), "post_reset_idle");
        for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("post_reset_row%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
